// File: rtl/tx_bit_sequencer.sv
// tx_bit_sequencer
// Drives the 5-bit select of the 32:1 bit mux and serialises the returned bit
// as a framed line: one start bit, NUM_BITS data bits, one stop bit. The select
// is always one bit ahead of the line (prefetch), so the mux path has a full
// bit period to settle before its output is sampled at the next boundary.

module tx_bit_sequencer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int NUM_BITS     = 32,
   parameter int MSB_FIRST    = 0,
   parameter int IDLE_LEVEL   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       ready,
   output logic       busy,
   output logic [4:0] sel,
   input  logic       mux_bit,
   output logic       tx_out,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [4:0]  FIRST_IDX  = (MSB_FIRST != 0) ? 5'(NUM_BITS - 1) : 5'd0;
   localparam logic [4:0]  LAST_COUNT = 5'(NUM_BITS - 1);
   localparam logic [15:0] LAST_CLK   = 16'(CLKS_PER_BIT - 1);
   localparam logic        IDLE_BIT   = (IDLE_LEVEL != 0);

   state_t      state;
   logic [15:0] clk_cnt;
   logic [4:0]  bit_cnt;
   logic [4:0]  step_sel;
   logic        at_boundary;

   // Handshake flags follow the state directly so a request can be accepted
   // in the same cycle the sequencer becomes idle.
   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);

   // The index after the current select, in the configured bit order.
   always_comb begin
      step_sel    = (MSB_FIRST != 0) ? (sel - 5'd1) : (sel + 5'd1);
      at_boundary = (clk_cnt == LAST_CLK);
   end

   // Frame sequencer: bit-period timing, select prefetch and line drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tx_out  <= IDLE_BIT;
         sel     <= FIRST_IDX;
         done    <= 1'b0;
         clk_cnt <= 16'd0;
         bit_cnt <= 5'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx_out  <= IDLE_BIT;
               sel     <= FIRST_IDX;
               clk_cnt <= 16'd0;
               bit_cnt <= 5'd0;
               if (start) begin
                  state  <= START;
                  tx_out <= ~IDLE_BIT;
               end
            end
            START: begin
               if (at_boundary) begin
                  clk_cnt <= 16'd0;
                  state   <= DATA;
                  tx_out  <= mux_bit;
                  bit_cnt <= 5'd0;
                  sel     <= (LAST_COUNT == 5'd0) ? FIRST_IDX : step_sel;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            DATA: begin
               if (at_boundary) begin
                  clk_cnt <= 16'd0;
                  if (bit_cnt == LAST_COUNT) begin
                     state  <= STOP;
                     tx_out <= IDLE_BIT;
                     sel    <= FIRST_IDX;
                  end else begin
                     tx_out  <= mux_bit;
                     bit_cnt <= bit_cnt + 5'd1;
                     sel     <= ((bit_cnt + 5'd1) == LAST_COUNT) ? FIRST_IDX : step_sel;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            STOP: begin
               if (at_boundary) begin
                  clk_cnt <= 16'd0;
                  state   <= IDLE;
                  done    <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_bit_sequencer.sv
// tb_tx_bit_sequencer
// Three sequencer configurations share one clock and reset. The driver pushes
// the expected per-cycle outputs into a scoreboard queue when it issues a
// frame; an independent monitor pops one entry per cycle and compares.

module tb_tx_bit_sequencer;

   logic clk;
   logic rst;

   // Instance A: CLKS_PER_BIT=4, NUM_BITS=32, LSB first
   logic        start_a, ready_a, busy_a, mux_a, tx_a, done_a, glitch_a;
   logic [4:0]  sel_a;
   logic [31:0] word_a;
   // Instance B: CLKS_PER_BIT=4, NUM_BITS=8, MSB first
   logic        start_b, ready_b, busy_b, mux_b, tx_b, done_b;
   logic [4:0]  sel_b;
   logic [31:0] word_b;
   // Instance C: CLKS_PER_BIT=2, NUM_BITS=1
   logic        start_c, ready_c, busy_c, mux_c, tx_c, done_c;
   logic [4:0]  sel_c;
   logic [31:0] word_c;

   // Mux models; instance A can be forced to flip its bit between boundaries.
   assign mux_a = word_a[sel_a] ^ glitch_a;
   assign mux_b = word_b[sel_b];
   assign mux_c = word_c[sel_c];

   tx_bit_sequencer #(.CLKS_PER_BIT(4), .NUM_BITS(32), .MSB_FIRST(0), .IDLE_LEVEL(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .ready(ready_a), .busy(busy_a),
      .sel(sel_a), .mux_bit(mux_a), .tx_out(tx_a), .done(done_a));

   tx_bit_sequencer #(.CLKS_PER_BIT(4), .NUM_BITS(8), .MSB_FIRST(1), .IDLE_LEVEL(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .busy(busy_b),
      .sel(sel_b), .mux_bit(mux_b), .tx_out(tx_b), .done(done_b));

   tx_bit_sequencer #(.CLKS_PER_BIT(2), .NUM_BITS(1), .MSB_FIRST(0), .IDLE_LEVEL(1)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .ready(ready_c), .busy(busy_c),
      .sel(sel_c), .mux_bit(mux_c), .tx_out(tx_c), .done(done_c));

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         inst;
      int         tid;
      int         idx;
      logic       tx;
      logic       busy;
      logic       done;
      logic [4:0] sel;
   } exp_t;

   exp_t sb[$];
   int   assertions = 0;
   int   failures   = 0;

   // Per-bit-period expectations (line level and select) for the frame
   // about to be issued; expanded into per-cycle entries by pushFrame.
   logic       per_line [0:33];
   logic [4:0] per_sel  [0:33];
   logic [4:0] sel_tab_b [0:9] = '{5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd7, 5'd7};

   task automatic checkOutput(input int tid, input int idx, input string name,
                              input logic [4:0] act, input logic [4:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL t%0d cycle %0d %s: got %0d, expected %0d", tid, idx, name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int inst, input logic s);
      case (inst)
         0:       start_a = s;
         1:       start_b = s;
         default: start_c = s;
      endcase
   endtask

   task automatic pushEntry(input int inst, input int tid, input int idx, input logic tx,
                            input logic bsy, input logic dn, input logic [4:0] s);
      exp_t e;
      e.inst = inst; e.tid = tid; e.idx = idx;
      e.tx = tx; e.busy = bsy; e.done = dn; e.sel = s;
      sb.push_back(e);
   endtask

   // One entry per cycle of the frame, then the done/IDLE cycle.
   task automatic pushFrame(input int inst, input int tid, input int cpb, input int periods,
                            input logic [4:0] first, input int maxn);
      int n = 0;
      for (int p = 0; p < periods; p++) begin
         for (int c = 0; c < cpb; c++) begin
            if (n < maxn) pushEntry(inst, tid, n, per_line[p], 1'b1, 1'b0, per_sel[p]);
            n++;
         end
      end
      if (n < maxn) pushEntry(inst, tid, n, 1'b1, 1'b0, 1'b1, first);
   endtask

   task automatic pushIdle(input int inst, input int tid, input int count, input logic [4:0] first);
      for (int i = 0; i < count; i++) pushEntry(inst, tid, 1000 + i, 1'b1, 1'b0, 1'b0, first);
   endtask

   // 32-bit LSB-first frame: start, word[0..31], stop; select runs one ahead.
   task automatic buildLsb(input logic [31:0] w);
      per_line[0] = 1'b0;
      per_sel[0]  = 5'd0;
      for (int b = 0; b < 32; b++) begin
         per_line[b + 1] = w[b];
         per_sel[b + 1]  = (b == 31) ? 5'd0 : 5'(b + 1);
      end
      per_line[33] = 1'b1;
      per_sel[33]  = 5'd0;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (sb.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      assertions++;
      if (sb.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: one scoreboard entry per cycle, sampled just after the edge.
   always @(posedge clk) begin
      exp_t       cur;
      logic       a_tx, a_busy, a_ready, a_done;
      logic [4:0] a_sel;
      #1;
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         case (cur.inst)
            0:       begin a_tx = tx_a; a_busy = busy_a; a_ready = ready_a; a_done = done_a; a_sel = sel_a; end
            1:       begin a_tx = tx_b; a_busy = busy_b; a_ready = ready_b; a_done = done_b; a_sel = sel_b; end
            default: begin a_tx = tx_c; a_busy = busy_c; a_ready = ready_c; a_done = done_c; a_sel = sel_c; end
         endcase
         checkOutput(cur.tid, cur.idx, "tx_out", {4'd0, a_tx},    {4'd0, cur.tx});
         checkOutput(cur.tid, cur.idx, "busy",   {4'd0, a_busy},  {4'd0, cur.busy});
         checkOutput(cur.tid, cur.idx, "ready",  {4'd0, a_ready}, {4'd0, ~cur.busy});
         checkOutput(cur.tid, cur.idx, "done",   {4'd0, a_done},  {4'd0, cur.done});
         checkOutput(cur.tid, cur.idx, "sel",    a_sel,           cur.sel);
      end
   end

   // Directed stimulus sequence
   initial begin
      rst = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      glitch_a = 1'b0;
      word_a = 32'h0; word_b = 32'h0; word_c = 32'h0;

      // Power-on reset state of all three configurations
      @(negedge clk);
      pushEntry(0, 0, 0, 1'b1, 1'b0, 1'b0, 5'd0);
      pushEntry(1, 0, 1, 1'b1, 1'b0, 1'b0, 5'd7);
      pushEntry(2, 0, 2, 1'b1, 1'b0, 1'b0, 5'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      waitDrain(20);

      // Test 1: reset for two cycles in the middle of DATA aborts the frame
      $display("[TB] test 1: mid-frame reset");
      word_a = 32'hA5A5_0F0F;
      buildLsb(word_a);
      pushFrame(0, 1, 4, 34, 5'd0, 18);
      pushIdle(0, 1, 10, 5'd0);
      applyStimulus(0, 1'b1);
      @(negedge clk);
      applyStimulus(0, 1'b0);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      waitDrain(40);

      // Test 2: LSB-first 32-bit frame, done on the 137th cycle
      $display("[TB] test 2: LSB-first frame");
      word_a = 32'hA5A5_0F0F;
      buildLsb(word_a);
      pushFrame(0, 2, 4, 34, 5'd0, 1000);
      applyStimulus(0, 1'b1);
      @(negedge clk);
      applyStimulus(0, 1'b0);
      waitDrain(200);

      // Test 3: MSB-first 8-bit frame of 8'h81, 40 cycles
      $display("[TB] test 3: MSB-first 8-bit frame");
      word_b = 32'h0000_0081;
      for (int p = 0; p < 10; p++) begin
         per_line[p] = (p == 1 || p == 8 || p == 9);
         per_sel[p]  = sel_tab_b[p];
      end
      pushFrame(1, 3, 4, 10, 5'd7, 1000);
      applyStimulus(1, 1'b1);
      @(negedge clk);
      applyStimulus(1, 1'b0);
      waitDrain(80);

      // Test 4: start held high gives three back-to-back frames, then idle
      $display("[TB] test 4: back-to-back frames");
      word_a = 32'hFFFF_0000;
      buildLsb(word_a);
      for (int f = 0; f < 3; f++) pushFrame(0, 4, 4, 34, 5'd0, 1000);
      pushIdle(0, 4, 5, 5'd0);
      applyStimulus(0, 1'b1);
      repeat (280) @(negedge clk);
      applyStimulus(0, 1'b0);
      waitDrain(300);

      // Test 5: shortest frame, two clocks per bit and a single data bit
      $display("[TB] test 5: one-bit frame");
      word_c = 32'h0000_0000;
      per_line[0] = 1'b0; per_line[1] = 1'b0; per_line[2] = 1'b1;
      per_sel[0]  = 5'd0; per_sel[1]  = 5'd0; per_sel[2]  = 5'd0;
      pushFrame(2, 5, 2, 3, 5'd0, 1000);
      pushIdle(2, 5, 3, 5'd0);
      applyStimulus(2, 1'b1);
      @(negedge clk);
      applyStimulus(2, 1'b0);
      waitDrain(30);

      // Test 6: mux glitches between boundaries and start pulses while busy
      $display("[TB] test 6: glitching mux, start while busy");
      word_a = 32'h1234_5678;
      buildLsb(word_a);
      pushFrame(0, 6, 4, 34, 5'd0, 1000);
      pushIdle(0, 6, 4, 5'd0);
      applyStimulus(0, 1'b1);
      for (int m = 1; m <= 136; m++) begin
         @(negedge clk);
         applyStimulus(0, (m == 20 || m == 60));
         glitch_a = ((m - 1) % 4 != 3);
      end
      @(negedge clk);
      glitch_a = 1'b0;
      waitDrain(40);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
